// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus scheduler: bus widths, source
// indices and the round-robin pointer helper.
package cdb_arbiter_pkg;

  localparam int ROBIDBus  = 4;
  localparam int DataWidth = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam int CDBSrcNum    = 3;
  localparam int CDBFifoDepth = 2;

  typedef enum logic [1:0] {
    CDB_ALU = 2'd0,
    CDB_LSB = 2'd1,
    CDB_BRU = 2'd2
  } cdb_src_e;

  // Round-robin successor of a source index, wrapping at num.
  function automatic logic [1:0] cdbNextSrc(input logic [1:0] cur, input int num);
    if (int'(cur) >= num - 1) begin
      return 2'd0;
    end
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Single-source result FIFO feeding the CDB arbiter; holds {rob_id, value}
// pairs and exposes the head entry, occupancy, full and empty.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH    = CDBFifoDepth,
  parameter int ROB_ID_W = ROBIDBus,
  parameter int DATA_W   = DataWidth
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rdy,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [ROB_ID_W-1:0]    i_push_rob_id,
  input  logic [DATA_W-1:0]      i_push_value,
  input  logic                   i_pop,
  output logic [ROB_ID_W-1:0]    o_head_rob_id,
  output logic [DATA_W-1:0]      o_head_value,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [ROB_ID_W-1:0] r_mem_id  [DEPTH];
  logic [DATA_W-1:0]   r_mem_val [DEPTH];

  logic w_active;
  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_active  = i_rst & i_rdy & ~i_flush;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = w_active & i_push & ~w_full;
  assign w_do_pop  = w_active & i_pop & ~w_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_rdy) begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_do_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem_id[r_wr_ptr]  <= i_push_rob_id;
      r_mem_val[r_wr_ptr] <= i_push_value;
    end
  end

  assign o_head_rob_id = r_mem_id[r_rd_ptr];
  assign o_head_value  = r_mem_val[r_rd_ptr];
  assign o_count       = r_count;
  assign o_full        = w_full;
  assign o_empty       = w_empty;

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus scheduler: buffers results from each execution unit and
// broadcasts one per cycle under round-robin arbitration, with flush support.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = CDBSrcNum,
  parameter int FIFO_DEPTH = CDBFifoDepth,
  parameter int ROB_ID_W   = ROBIDBus,
  parameter int DATA_W     = DataWidth
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_rdy,
  input  logic                        i_flush,
  input  logic [NUM_SRC-1:0]          i_src_valid,
  input  logic [NUM_SRC*ROB_ID_W-1:0] i_src_rob_id,
  input  logic [NUM_SRC*DATA_W-1:0]   i_src_value,
  output logic [NUM_SRC-1:0]          o_src_ready,
  output logic                        o_cdb_valid,
  output logic [ROB_ID_W-1:0]         o_cdb_rob_id,
  output logic [DATA_W-1:0]           o_cdb_value,
  output logic [1:0]                  o_cdb_src
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0]  w_push;
  logic [NUM_SRC-1:0]  w_pop;
  logic [NUM_SRC-1:0]  w_full;
  logic [NUM_SRC-1:0]  w_empty;
  logic [NUM_SRC-1:0]  w_src_ready;
  logic [CW-1:0]       w_count    [NUM_SRC];
  logic [ROB_ID_W-1:0] w_head_id  [NUM_SRC];
  logic [DATA_W-1:0]   w_head_val [NUM_SRC];

  logic                w_normal;
  logic                w_found;
  logic [1:0]          w_winner;
  logic [ROB_ID_W-1:0] w_win_id;
  logic [DATA_W-1:0]   w_win_val;
  int                  w_idx;

  logic [1:0]          r_ptr;
  logic                r_cdb_valid;
  logic [ROB_ID_W-1:0] r_cdb_rob_id;
  logic [DATA_W-1:0]   r_cdb_value;
  logic [1:0]          r_cdb_src;

  assign w_normal = i_rst & i_rdy & ~i_flush;

  // Ready looks only at the current count, so a full FIFO being popped this
  // cycle still refuses a push.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_src_ready[g] = w_normal & (w_count[g] != CW'(FIFO_DEPTH));
    assign w_push[g]      = i_src_valid[g] & w_src_ready[g] & ~w_full[g];
    assign w_pop[g]       = w_normal & w_found & (w_winner == 2'(g));

    cdb_src_fifo #(
      .DEPTH    (FIFO_DEPTH),
      .ROB_ID_W (ROB_ID_W),
      .DATA_W   (DATA_W)
    ) u_fifo (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_rdy         (i_rdy),
      .i_flush       (i_flush),
      .i_push        (w_push[g]),
      .i_push_rob_id (i_src_rob_id[g*ROB_ID_W +: ROB_ID_W]),
      .i_push_value  (i_src_value[g*DATA_W +: DATA_W]),
      .i_pop         (w_pop[g]),
      .o_head_rob_id (w_head_id[g]),
      .o_head_value  (w_head_val[g]),
      .o_count       (w_count[g]),
      .o_full        (w_full[g]),
      .o_empty       (w_empty[g])
    );
  end

  // First non-empty FIFO at or after the pointer, wrapping, wins the bus.
  always_comb begin
    w_found   = False;
    w_winner  = '0;
    w_win_id  = '0;
    w_win_val = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_SRC) begin
        w_idx = w_idx - NUM_SRC;
      end
      if (!w_found && !w_empty[w_idx]) begin
        w_found   = True;
        w_winner  = 2'(w_idx);
        w_win_id  = w_head_id[w_idx];
        w_win_val = w_head_val[w_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ptr        <= '0;
      r_cdb_valid  <= False;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_src    <= 2'(CDB_ALU);
    end else if (i_rdy) begin
      if (i_flush) begin
        r_ptr       <= '0;
        r_cdb_valid <= False;
      end else if (w_found) begin
        r_cdb_valid  <= True;
        r_cdb_rob_id <= w_win_id;
        r_cdb_value  <= w_win_val;
        r_cdb_src    <= w_winner;
        r_ptr        <= cdbNextSrc(w_winner, NUM_SRC);
      end else begin
        r_cdb_valid <= False;
      end
    end
  end

  assign o_src_ready  = w_src_ready;
  assign o_cdb_valid  = r_cdb_valid;
  assign o_cdb_rob_id = r_cdb_rob_id;
  assign o_cdb_value  = r_cdb_value;
  assign o_cdb_src    = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table plus multi-cycle sequences,
// checked against a cycle model through an expected-output queue.
module tb_cdb_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_rdy;
  logic        i_flush;
  logic [2:0]  i_src_valid;
  logic [11:0] i_src_rob_id;
  logic [95:0] i_src_value;
  logic [2:0]  o_src_ready;
  logic        o_cdb_valid;
  logic [3:0]  o_cdb_rob_id;
  logic [31:0] o_cdb_value;
  logic [1:0]  o_cdb_src;

  cdb_arbiter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rdy        (i_rdy),
    .i_flush      (i_flush),
    .i_src_valid  (i_src_valid),
    .i_src_rob_id (i_src_rob_id),
    .i_src_value  (i_src_value),
    .o_src_ready  (o_src_ready),
    .o_cdb_valid  (o_cdb_valid),
    .o_cdb_rob_id (o_cdb_rob_id),
    .o_cdb_value  (o_cdb_value),
    .o_cdb_src    (o_cdb_src)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v;
    logic [3:0]  id;
    logic [31:0] val;
    logic [1:0]  src;
  } cdbExp_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [2:0]  valid;
    logic [11:0] ids;
    logic [95:0] vals;
    logic        eValid;
    logic [3:0]  eId;
    logic [31:0] eVal;
    logic [1:0]  eSrc;
    logic [2:0]  eReady;
  } vec_t;

  int checks = 0;
  int errors = 0;

  cdbExp_t     expQ[$];
  int          mCnt [3];
  logic [3:0]  mIdQ [3][2];
  logic [31:0] mValQ[3][2];
  int          mPtr;
  logic        mValid;
  logic [3:0]  mId;
  logic [31:0] mVal;
  logic [1:0]  mSrc;
  int          grantCnt[3];

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Cycle model: pop the round-robin winner, then append accepted pushes.
  task automatic modelStep(input logic rst, input logic rdy, input logic flush,
                           input logic [2:0] acc, input logic [11:0] ids, input logic [95:0] vals);
    int win;
    cdbExp_t e;
    if (!rst) begin
      for (int i = 0; i < 3; i++) mCnt[i] = 0;
      mPtr = 0; mValid = 1'b0; mId = '0; mVal = '0; mSrc = '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < 3; i++) mCnt[i] = 0;
        mPtr = 0; mValid = 1'b0;
      end else begin
        win = -1;
        for (int k = 0; k < 3; k++) begin
          if (win < 0 && mCnt[(mPtr + k) % 3] > 0) win = (mPtr + k) % 3;
        end
        if (win >= 0) begin
          mValid = 1'b1;
          mId    = mIdQ[win][0];
          mVal   = mValQ[win][0];
          mSrc   = 2'(win);
          mIdQ[win][0]  = mIdQ[win][1];
          mValQ[win][0] = mValQ[win][1];
          mCnt[win]--;
          mPtr = (win + 1) % 3;
        end else begin
          mValid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
          if (acc[i]) begin
            mIdQ[i][mCnt[i]]  = ids[i*4 +: 4];
            mValQ[i][mCnt[i]] = vals[i*32 +: 32];
            mCnt[i]++;
          end
        end
      end
    end
    e.v = mValid; e.id = mId; e.val = mVal; e.src = mSrc;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    cdbExp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = expQ.pop_front();
      expectEq("cdb_valid",  32'(o_cdb_valid),  32'(e.v));
      expectEq("cdb_rob_id", 32'(o_cdb_rob_id), 32'(e.id));
      expectEq("cdb_value",  o_cdb_value,       e.val);
      expectEq("cdb_src",    32'(o_cdb_src),    32'(e.src));
    end
    if (o_cdb_valid) grantCnt[o_cdb_src]++;
  endtask

  // Drives one cycle: ready is checked before the edge, outputs after it.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic flush,
                               input logic [2:0] v, input logic [11:0] ids, input logic [95:0] vals,
                               output logic [2:0] acc, output logic [2:0] rdyObs);
    logic [2:0] mReady;
    i_rst = rst; i_rdy = rdy; i_flush = flush;
    i_src_valid = v; i_src_rob_id = ids; i_src_value = vals;
    #1;
    for (int i = 0; i < 3; i++) mReady[i] = rst & rdy & ~flush & (mCnt[i] != 2);
    rdyObs = o_src_ready;
    expectEq("src_ready", 32'(o_src_ready), 32'(mReady));
    acc = v & mReady;
    modelStep(rst, rdy, flush, acc, ids, vals);
    @(posedge i_clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs[14];
    logic [2:0] acc;
    logic [2:0] rdyObs;
    logic [3:0] aNext;
    logic       accepted;
    int         fairExp[3];

    i_rst = 1'b0; i_rdy = 1'b1; i_flush = 1'b0;
    i_src_valid = '0; i_src_rob_id = '0; i_src_value = '0;
    for (int i = 0; i < 3; i++) begin
      mCnt[i] = 0; grantCnt[i] = 0;
      for (int j = 0; j < 2; j++) begin mIdQ[i][j] = '0; mValQ[i][j] = '0; end
    end
    mPtr = 0; mValid = 1'b0; mId = '0; mVal = '0; mSrc = '0;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b0, 4'd0, 32'h0,  2'd0, 3'b000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'b001, 12'h003, {32'h0, 32'h0, 32'h11}, 1'b0, 4'd0, 32'h0, 2'd0, 3'b111};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'd3, 32'h11, 2'd0, 3'b111};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b0, 4'd3, 32'h11, 2'd0, 3'b111};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 3'b000, 12'h000, 96'h0, 1'b0, 4'd3, 32'h11, 2'd0, 3'b000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b111, 12'h321, {32'hA2, 32'hA1, 32'hA0}, 1'b0, 4'd3, 32'h11, 2'd0, 3'b111};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'd1, 32'hA0, 2'd0, 3'b111};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'd2, 32'hA1, 2'd1, 3'b111};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'd3, 32'hA2, 2'd2, 3'b111};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b0, 4'd3, 32'hA2, 2'd2, 3'b111};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b101, 12'h605, {32'hB2, 32'h0, 32'hB0}, 1'b0, 4'd3, 32'hA2, 2'd2, 3'b111};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'd5, 32'hB0, 2'd0, 3'b111};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'd6, 32'hB2, 2'd2, 3'b111};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b0, 4'd6, 32'hB2, 2'd2, 3'b111};

    $display("[TB] directed vector table");
    for (int r = 0; r < 14; r++) begin
      applyStimulus(vecs[r].rst, vecs[r].rdy, vecs[r].flush, vecs[r].valid,
                    vecs[r].ids, vecs[r].vals, acc, rdyObs);
      expectEq($sformatf("tbl%0d_ready", r), 32'(rdyObs),       32'(vecs[r].eReady));
      expectEq($sformatf("tbl%0d_valid", r), 32'(o_cdb_valid),  32'(vecs[r].eValid));
      expectEq($sformatf("tbl%0d_id", r),    32'(o_cdb_rob_id), 32'(vecs[r].eId));
      expectEq($sformatf("tbl%0d_value", r), o_cdb_value,       vecs[r].eVal);
      expectEq($sformatf("tbl%0d_src", r),   32'(o_cdb_src),    32'(vecs[r].eSrc));
    end

    $display("[TB] back-pressure on LSB");
    for (int i = 0; i < 3; i++) grantCnt[i] = 0;
    applyStimulus(1, 1, 0, 3'b111, 12'h741, {32'hC7, 32'hC4, 32'hC1}, acc, rdyObs);
    applyStimulus(1, 1, 0, 3'b111, 12'h852, {32'hC8, 32'hC5, 32'hC2}, acc, rdyObs);
    expectEq("bp_lsb_full", 32'(o_src_ready[1]), 32'd0);
    applyStimulus(1, 1, 0, 3'b010, 12'h060, {32'h0, 32'hC6, 32'h0}, acc, rdyObs);
    expectEq("bp_held_refused", 32'(rdyObs[1]), 32'd0);
    accepted = 1'b0;
    for (int n = 0; n < 8 && !accepted; n++) begin
      applyStimulus(1, 1, 0, 3'b010, 12'h060, {32'h0, 32'hC6, 32'h0}, acc, rdyObs);
      accepted = acc[1];
    end
    for (int n = 0; n < 8; n++) applyStimulus(1, 1, 0, 3'b000, 12'h0, 96'h0, acc, rdyObs);
    expectEq("bp_lsb_grants", grantCnt[1], 32'd3);

    $display("[TB] fairness ALU vs BRU");
    applyStimulus(1, 1, 1, 3'b000, 12'h0, 96'h0, acc, rdyObs);
    aNext = 4'd1;
    applyStimulus(1, 1, 0, 3'b101, {4'hB, 4'h0, aNext}, {32'hBB, 32'h0, 32'hF00 + 32'(aNext)}, acc, rdyObs);
    if (acc[0]) aNext = aNext + 4'd1;
    fairExp = '{0, 2, 0};
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 1, 0, 3'b001, {8'h0, aNext}, {64'h0, 32'hF00 + 32'(aNext)}, acc, rdyObs);
      if (acc[0]) aNext = aNext + 4'd1;
      if (k < 3) begin
        expectEq($sformatf("fair%0d_valid", k), 32'(o_cdb_valid), 32'd1);
        expectEq($sformatf("fair%0d_src", k),   32'(o_cdb_src),   32'(fairExp[k]));
      end
      if (k == 1) expectEq("fair_bru_id", 32'(o_cdb_rob_id), 32'hB);
    end
    for (int n = 0; n < 5; n++) applyStimulus(1, 1, 0, 3'b000, 12'h0, 96'h0, acc, rdyObs);

    $display("[TB] flush with pending entries");
    applyStimulus(1, 1, 0, 3'b111, 12'hCBA, {32'hDC, 32'hDB, 32'hDA}, acc, rdyObs);
    applyStimulus(1, 1, 0, 3'b111, 12'hFED, {32'hDF, 32'hDE, 32'hDD}, acc, rdyObs);
    applyStimulus(1, 1, 1, 3'b000, 12'h0, 96'h0, acc, rdyObs);
    expectEq("flush_valid", 32'(o_cdb_valid), 32'd0);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1, 1, 0, 3'b000, 12'h0, 96'h0, acc, rdyObs);
      if (n == 0) expectEq("flush_ready", 32'(rdyObs), 32'h7);
      expectEq($sformatf("flush_no_stale%0d", n), 32'(o_cdb_valid), 32'd0);
    end

    $display("[TB] rdy low freeze");
    applyStimulus(1, 1, 0, 3'b111, 12'h321, {32'hE2, 32'hE1, 32'hE0}, acc, rdyObs);
    applyStimulus(1, 1, 0, 3'b000, 12'h0, 96'h0, acc, rdyObs);
    expectEq("rdy_pre_valid", 32'(o_cdb_valid), 32'd1);
    expectEq("rdy_pre_src",   32'(o_cdb_src),   32'd0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1, 0, 0, 3'b000, 12'h0, 96'h0, acc, rdyObs);
      expectEq($sformatf("rdy_low%0d_ready", n), 32'(rdyObs),       32'd0);
      expectEq($sformatf("rdy_low%0d_valid", n), 32'(o_cdb_valid),  32'd1);
      expectEq($sformatf("rdy_low%0d_id", n),    32'(o_cdb_rob_id), 32'd1);
      expectEq($sformatf("rdy_low%0d_value", n), o_cdb_value,       32'hE0);
    end
    applyStimulus(1, 1, 0, 3'b000, 12'h0, 96'h0, acc, rdyObs);
    expectEq("rdy_resume_src", 32'(o_cdb_src),    32'd1);
    expectEq("rdy_resume_id",  32'(o_cdb_rob_id), 32'd2);
    for (int n = 0; n < 3; n++) applyStimulus(1, 1, 0, 3'b000, 12'h0, 96'h0, acc, rdyObs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common-data-bus scheduler: collects results from execution units (ALU, LSB, branch unit), buffers each source in a small FIFO, and grants one result per cycle onto the CDB.
- The CDB is the single wakeup path (ROB id + value) consumed by the reservation station, the LSB and the ROB.
- Round-robin arbitration gives every unit bounded latency.
- Flush support discards wrong-path results after a misprediction.

Parameters:
- NUM_SRC, 3, number of result sources (0=ALU, 1=LSB, 2=BRU)
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2
- ROB_ID_W, 4, ROB id width (matches ROBIDBus)
- DATA_W, 32, result width (matches DataWidth)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global ready; low = freeze all state
- flush  in  1  misprediction clear from ROB
- src_valid  in  NUM_SRC  per-source result valid
- src_rob_id  in  NUM_SRC*ROB_ID_W  packed ROB ids; source i occupies bits [i*ROB_ID_W +: ROB_ID_W]
- src_value  in  NUM_SRC*DATA_W  packed result values; same packing as src_rob_id
- src_ready  out  NUM_SRC  per-source FIFO can accept this cycle
- cdb_valid  out  1  broadcast valid
- cdb_rob_id  out  ROB_ID_W  broadcast ROB id
- cdb_value  out  DATA_W  broadcast value
- cdb_src  out  2  index of the granted source

Behaviour:
Reset (rst==0 at a clock edge):
- All FIFOs empty. Round-robin pointer = 0.
- cdb_valid = 0, cdb_rob_id = 0, cdb_value = 0, cdb_src = 0.
- src_ready = 0 while rst is low.

Priority at each edge: reset > rdy low > flush > normal operation.

rdy low:
- No push, no pop, pointer unchanged, CDB registers hold their values.
- src_ready = 0.

src_ready[i] = rst & rdy & !flush & (count[i] != FIFO_DEPTH).
- Combinational from the current count only.
- Does not account for a same-cycle pop, so a full FIFO that is popped still refuses a push that cycle.

Push: when src_valid[i] & src_ready[i], the entry {rob_id, value} is written at the FIFO[i] tail.
- src_valid while src_ready is low is a protocol violation. The producer must hold; the result is not captured.

Arbitration (normal cycle, combinational over current FIFO heads):
- Candidates are the non-empty FIFOs, searched starting from the pointer and wrapping modulo NUM_SRC. The first candidate wins.
- At the edge: pop the winner; cdb_valid <= 1; cdb_rob_id/cdb_value <= head of the winner; cdb_src <= winner index; pointer <= (winner+1) mod NUM_SRC.
- No candidate: cdb_valid <= 0, pointer unchanged, cdb_rob_id/cdb_value/cdb_src hold.
- Push and pop on the same FIFO in one cycle are both performed; count is unchanged.
- An entry pushed at edge E is never granted at E; its earliest grant is edge E+1. cdb_valid is high for exactly one cycle per grant.

Flush (at an edge with rdy=1):
- All FIFOs emptied, cdb_valid <= 0, pointer <= 0.
- Pushes presented in the flush cycle are discarded (src_ready is low).

Pointers and counts:
- FIFO read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Count is log2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.

Decomposition:
- Shared defines file: CDBSrcNum, CDBFifoDepth, and source indices CDB_ALU=0, CDB_LSB=1, CDB_BRU=2.
- Reuse the existing ROBIDBus, DataWidth, True and False.
- One sub-module, cdb_src_fifo: single-source FIFO with push, pop, flush, head, count, full and empty. Instantiated NUM_SRC times.
- Round-robin selection stays inline in cdb_arbiter.

Test Plan:
- Reset then single push: ALU pushes {id=3, val=0x11} at edge 1 -> at edge 2 cdb_valid=1, cdb_rob_id=3, cdb_value=0x11, cdb_src=0; at edge 3 cdb_valid=0.
- All three sources push at the same edge with pointer=0: ids 1, 2, 3 -> grants on consecutive cycles in order src 0, 1, 2; pointer ends at 0.
- Back-pressure: stall draining by keeping other sources busy; LSB pushes 2 entries -> src_ready[1]=0; a third push held by the producer is accepted only after the first pop, with no loss and no duplication.
- Fairness: ALU pushes every cycle while BRU holds one entry -> BRU is granted within NUM_SRC cycles; cdb_src sequence 0, 2, 0, ...
- Flush: all FIFOs hold entries, assert flush for 1 cycle -> next cycle cdb_valid=0, all src_ready=1, no stale id ever appears on the CDB.
- rdy low for 3 cycles with pending entries and cdb_valid=1 -> all outputs frozen; src_ready=0; on rdy return, arbitration resumes from the held pointer.
